// File: rtl/result_packer.sv
// Two-stage floating-point result packer: selects each field of the IEEE-style word from operand A/B,
// the computed result or a constant, applies infinity / flush-to-zero overrides and raises sticky flags.
module result_packer #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [1:0]                      sign_select,
  input  logic [2:0]                      exponent_select,
  input  logic [2:0]                      fraction_msb_select,
  input  logic [1:0]                      fraction_lsbs_select,
  input  logic                            operand_sign_a,
  input  logic                            operand_sign_b,
  input  logic [EXP_WIDTH-1:0]            operand_exponent_a,
  input  logic [EXP_WIDTH-1:0]            operand_exponent_b,
  input  logic [FRAC_WIDTH:0]             operand_fraction_a,
  input  logic [FRAC_WIDTH:0]             operand_fraction_b,
  input  logic                            result_sign,
  input  logic [EXP_WIDTH+1:0]            result_exponent,
  input  logic [FRAC_WIDTH+1:0]           result_fraction,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [EXP_WIDTH+FRAC_WIDTH:0]   result,
  output logic                            flag_overflow,
  output logic                            flag_underflow,
  input  logic                            flag_clear
);

  // Select encodings: 0 = A, 1 = B, 2 = RESULT, 3 = ZERO(S), 4 = ONE(S); anything else reads as zero.
  localparam logic signed [EXP_WIDTH+1:0] EXP_MAX  = (EXP_WIDTH+2)'((1 << EXP_WIDTH) - 1);
  localparam logic signed [EXP_WIDTH+1:0] EXP_ZERO = '0;

  logic                    s1_valid;
  logic [1:0]              s1_sign_sel;
  logic [2:0]              s1_exp_sel;
  logic [2:0]              s1_msb_sel;
  logic [1:0]              s1_lsbs_sel;
  logic                    s1_sign_a;
  logic                    s1_sign_b;
  logic [EXP_WIDTH-1:0]    s1_exp_a;
  logic [EXP_WIDTH-1:0]    s1_exp_b;
  logic [FRAC_WIDTH-1:0]   s1_frac_a;
  logic [FRAC_WIDTH-1:0]   s1_frac_b;
  logic                    s1_res_sign;
  logic [EXP_WIDTH-1:0]    s1_res_exp;
  logic [FRAC_WIDTH-1:0]   s1_res_frac;
  logic                    s1_overflow;
  logic                    s1_underflow;

  logic                    s2_overflow;
  logic                    s2_underflow;

  logic                    s1_advance;
  logic                    s2_advance;
  logic                    in_overflow;
  logic                    in_underflow;
  logic [2:0]              eff_exp_sel;
  logic [2:0]              eff_msb_sel;
  logic [1:0]              eff_lsbs_sel;

  logic                    asm_sign;
  logic [EXP_WIDTH-1:0]    asm_exp;
  logic                    asm_msb;
  logic [FRAC_WIDTH-2:0]   asm_lsbs;

  // Hidden bits and result-fraction guard bits never reach the packed word.
  logic                    unused_hidden_bits;
  assign unused_hidden_bits = ^{operand_fraction_a[FRAC_WIDTH], operand_fraction_b[FRAC_WIDTH],
                                result_fraction[FRAC_WIDTH+1:FRAC_WIDTH]};

  assign s2_advance = !out_valid || out_ready;
  assign s1_advance = !s1_valid || s2_advance;
  assign in_ready   = s1_advance;

  assign in_overflow  = (exponent_select == 3'd2) && ($signed(result_exponent) >= EXP_MAX);
  assign in_underflow = (exponent_select == 3'd2) && ($signed(result_exponent) <= EXP_ZERO);

  // Out-of-range result exponents rewrite the selects so stage 2 emits infinity or a signed zero.
  always_comb begin
    eff_exp_sel  = exponent_select;
    eff_msb_sel  = fraction_msb_select;
    eff_lsbs_sel = fraction_lsbs_select;
    if (in_overflow) begin
      eff_exp_sel  = 3'd4;
      eff_msb_sel  = 3'd3;
      eff_lsbs_sel = 2'd3;
    end else if (in_underflow) begin
      eff_exp_sel  = 3'd3;
      eff_msb_sel  = 3'd3;
      eff_lsbs_sel = 2'd3;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid     <= 1'b0;
      s1_sign_sel  <= '0;
      s1_exp_sel   <= '0;
      s1_msb_sel   <= '0;
      s1_lsbs_sel  <= '0;
      s1_sign_a    <= 1'b0;
      s1_sign_b    <= 1'b0;
      s1_exp_a     <= '0;
      s1_exp_b     <= '0;
      s1_frac_a    <= '0;
      s1_frac_b    <= '0;
      s1_res_sign  <= 1'b0;
      s1_res_exp   <= '0;
      s1_res_frac  <= '0;
      s1_overflow  <= 1'b0;
      s1_underflow <= 1'b0;
    end else if (s1_advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign_sel  <= sign_select;
        s1_exp_sel   <= eff_exp_sel;
        s1_msb_sel   <= eff_msb_sel;
        s1_lsbs_sel  <= eff_lsbs_sel;
        s1_sign_a    <= operand_sign_a;
        s1_sign_b    <= operand_sign_b;
        s1_exp_a     <= operand_exponent_a;
        s1_exp_b     <= operand_exponent_b;
        s1_frac_a    <= operand_fraction_a[FRAC_WIDTH-1:0];
        s1_frac_b    <= operand_fraction_b[FRAC_WIDTH-1:0];
        s1_res_sign  <= result_sign;
        s1_res_exp   <= result_exponent[EXP_WIDTH-1:0];
        s1_res_frac  <= result_fraction[FRAC_WIDTH-1:0];
        s1_overflow  <= in_overflow;
        s1_underflow <= in_underflow;
      end
    end
  end

  always_comb begin
    asm_sign = 1'b0;
    asm_exp  = '0;
    asm_msb  = 1'b0;
    asm_lsbs = '0;
    case (s1_sign_sel)
      2'd0:    asm_sign = s1_sign_a;
      2'd1:    asm_sign = s1_sign_b;
      2'd2:    asm_sign = s1_res_sign;
      default: asm_sign = 1'b0;
    endcase
    case (s1_exp_sel)
      3'd0:    asm_exp = s1_exp_a;
      3'd1:    asm_exp = s1_exp_b;
      3'd2:    asm_exp = s1_res_exp;
      3'd4:    asm_exp = '1;
      default: asm_exp = '0;
    endcase
    case (s1_msb_sel)
      3'd0:    asm_msb = s1_frac_a[FRAC_WIDTH-1];
      3'd1:    asm_msb = s1_frac_b[FRAC_WIDTH-1];
      3'd2:    asm_msb = s1_res_frac[FRAC_WIDTH-1];
      3'd4:    asm_msb = 1'b1;
      default: asm_msb = 1'b0;
    endcase
    case (s1_lsbs_sel)
      2'd0:    asm_lsbs = s1_frac_a[FRAC_WIDTH-2:0];
      2'd1:    asm_lsbs = s1_frac_b[FRAC_WIDTH-2:0];
      2'd2:    asm_lsbs = s1_res_frac[FRAC_WIDTH-2:0];
      default: asm_lsbs = '0;
    endcase
  end

  // Stage 2 keeps its word untouched while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      result       <= '0;
      s2_overflow  <= 1'b0;
      s2_underflow <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result       <= {asm_sign, asm_exp, asm_msb, asm_lsbs};
        s2_overflow  <= s1_overflow;
        s2_underflow <= s1_underflow;
      end
    end
  end

  // A new event wins over a clear landing on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
    end else begin
      if (out_valid && out_ready && s2_overflow) begin
        flag_overflow <= 1'b1;
      end else if (flag_clear) begin
        flag_overflow <= 1'b0;
      end
      if (out_valid && out_ready && s2_underflow) begin
        flag_underflow <= 1'b1;
      end else if (flag_clear) begin
        flag_underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_result_packer.sv
// Testbench for result_packer: table of field-select vectors through a scoreboard, plus hand-written
// sequences for latency, sticky flags, backpressure, mid-flight reset and a half-precision build.
module tb_result_packer;

  localparam int EW  = 8;
  localparam int FW  = 23;
  localparam int SEW = 5;
  localparam int SFW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset_n;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          sign_select;
  logic [2:0]          exponent_select;
  logic [2:0]          fraction_msb_select;
  logic [1:0]          fraction_lsbs_select;
  logic                operand_sign_a;
  logic                operand_sign_b;
  logic [EW-1:0]       operand_exponent_a;
  logic [EW-1:0]       operand_exponent_b;
  logic [FW:0]         operand_fraction_a;
  logic [FW:0]         operand_fraction_b;
  logic                result_sign;
  logic [EW+1:0]       result_exponent;
  logic [FW+1:0]       result_fraction;
  logic                out_valid;
  logic                out_ready;
  logic [EW+FW:0]      result;
  logic                flag_overflow;
  logic                flag_underflow;
  logic                flag_clear;

  logic                s_in_valid;
  logic                s_in_ready;
  logic                s_operand_sign_a;
  logic [SEW-1:0]      s_operand_exponent_a;
  logic [SFW:0]        s_operand_fraction_a;
  logic                s_out_valid;
  logic                s_out_ready;
  logic [SEW+SFW:0]    s_result;
  logic                s_flag_overflow;
  logic                s_flag_underflow;

  result_packer #(.EXP_WIDTH(EW), .FRAC_WIDTH(FW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .sign_select(sign_select), .exponent_select(exponent_select),
    .fraction_msb_select(fraction_msb_select), .fraction_lsbs_select(fraction_lsbs_select),
    .operand_sign_a(operand_sign_a), .operand_sign_b(operand_sign_b),
    .operand_exponent_a(operand_exponent_a), .operand_exponent_b(operand_exponent_b),
    .operand_fraction_a(operand_fraction_a), .operand_fraction_b(operand_fraction_b),
    .result_sign(result_sign), .result_exponent(result_exponent), .result_fraction(result_fraction),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_overflow(flag_overflow), .flag_underflow(flag_underflow), .flag_clear(flag_clear)
  );

  result_packer #(.EXP_WIDTH(SEW), .FRAC_WIDTH(SFW)) dut_half (
    .clk(clk), .reset_n(reset_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .sign_select(2'd0), .exponent_select(3'd0),
    .fraction_msb_select(3'd0), .fraction_lsbs_select(2'd0),
    .operand_sign_a(s_operand_sign_a), .operand_sign_b(1'b0),
    .operand_exponent_a(s_operand_exponent_a), .operand_exponent_b('0),
    .operand_fraction_a(s_operand_fraction_a), .operand_fraction_b('0),
    .result_sign(1'b0), .result_exponent('0), .result_fraction('0),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result),
    .flag_overflow(s_flag_overflow), .flag_underflow(s_flag_underflow), .flag_clear(1'b0)
  );

  typedef struct {
    logic [1:0]    ss;
    logic [2:0]    es;
    logic [2:0]    ms;
    logic [1:0]    ls;
    logic          sa;
    logic [EW-1:0] ea;
    logic [FW:0]   fa;
    logic          sb;
    logic [EW-1:0] eb;
    logic [FW:0]   fb;
    logic          rs;
    logic [EW+1:0] re;
    logic [FW+1:0] rf;
    logic [31:0]   exp_result;
    logic          exp_ovf;
    logic          exp_unf;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } exp_t;

  vec_t vecs[13];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic model_ovf = 1'b0;
  logic model_unf = 1'b0;

  function automatic vec_t mk(input logic [1:0] ss, input logic [2:0] es, input logic [2:0] ms,
                              input logic [1:0] ls, input logic sa, input logic [EW-1:0] ea,
                              input logic [FW:0] fa, input logic sb, input logic [EW-1:0] eb,
                              input logic [FW:0] fb, input logic rs, input logic [EW+1:0] re,
                              input logic [FW+1:0] rf, input logic [31:0] res,
                              input logic ovf, input logic unf);
    vec_t v;
    v.ss = ss; v.es = es; v.ms = ms; v.ls = ls;
    v.sa = sa; v.ea = ea; v.fa = fa;
    v.sb = sb; v.eb = eb; v.fb = fb;
    v.rs = rs; v.re = re; v.rf = rf;
    v.exp_result = res; v.exp_ovf = ovf; v.exp_unf = unf;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic driveInputs(input vec_t v);
    sign_select          = v.ss;
    exponent_select      = v.es;
    fraction_msb_select  = v.ms;
    fraction_lsbs_select = v.ls;
    operand_sign_a       = v.sa;
    operand_exponent_a   = v.ea;
    operand_fraction_a   = v.fa;
    operand_sign_b       = v.sb;
    operand_exponent_b   = v.eb;
    operand_fraction_b   = v.fb;
    result_sign          = v.rs;
    result_exponent      = v.re;
    result_fraction      = v.rf;
  endtask

  // Holds the word until accepted, queues its expectation, returns #1 after the accepting edge.
  task automatic applyStimulus(input vec_t v);
    bit done;
    done = 1'b0;
    driveInputs(v);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back('{v.exp_result, v.exp_ovf, v.exp_unf});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout actual=in_ready_low expected=accept");
    end
  endtask

  task automatic drainPipe();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !out_valid) break;
    end
    checkOutput("drain_empty", {63'd0, (sb_q.size() != 0) || out_valid}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulseClear();
    flag_clear = 1'b1;
    @(posedge clk);
    #1;
    flag_clear = 1'b0;
  endtask

  // Output monitor: pops the scoreboard on every transfer and tracks the sticky flags.
  initial begin
    exp_t e;
    logic set_o;
    logic set_u;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        model_ovf = 1'b0;
        model_unf = 1'b0;
      end else begin
        checkOutput("flag_overflow_track", flag_overflow, model_ovf);
        checkOutput("flag_underflow_track", flag_underflow, model_unf);
        set_o = 1'b0;
        set_u = 1'b0;
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output actual=%0h expected=none", result);
          end else begin
            e = sb_q.pop_front();
            checkOutput("result", result, e.res);
            set_o = e.ovf;
            set_u = e.unf;
          end
        end
        if (set_o) model_ovf = 1'b1;
        else if (flag_clear) model_ovf = 1'b0;
        if (set_u) model_unf = 1'b1;
        else if (flag_clear) model_unf = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    //          ss    es    ms    ls    sa    ea      fa          sb    eb      fb          rs    re        rf            result        ovf   unf
    vecs[0]  = mk(2'd2, 3'd2, 3'd2, 2'd2, 1'b0, 8'h00, 24'h000000, 1'b0, 8'h00, 24'h000000, 1'b1, 10'd127,  25'h0C00000, 32'hBFC00000, 1'b0, 1'b0);
    vecs[1]  = mk(2'd2, 3'd2, 3'd2, 2'd2, 1'b0, 8'h00, 24'h000000, 1'b0, 8'h00, 24'h000000, 1'b0, 10'd255,  25'h0C00000, 32'h7F800000, 1'b1, 1'b0);
    vecs[2]  = mk(2'd2, 3'd2, 3'd2, 2'd2, 1'b0, 8'h00, 24'h000000, 1'b0, 8'h00, 24'h000000, 1'b1, 10'h3FD,  25'h0C00000, 32'h80000000, 1'b0, 1'b1);
    vecs[3]  = mk(2'd3, 3'd4, 3'd4, 2'd3, 1'b1, 8'h12, 24'hFFFFFF, 1'b1, 8'h34, 24'hFFFFFF, 1'b1, 10'h3FD,  25'h1FFFFFF, 32'h7FC00000, 1'b0, 1'b0);
    vecs[4]  = mk(2'd0, 3'd0, 3'd0, 2'd0, 1'b1, 8'h81, 24'hA00001, 1'b0, 8'h00, 24'h000000, 1'b0, 10'd0,    25'h0000000, 32'hC0A00001, 1'b0, 1'b0);
    vecs[5]  = mk(2'd1, 3'd1, 3'd1, 2'd1, 1'b1, 8'h00, 24'h000000, 1'b0, 8'h7E, 24'hFFFFFF, 1'b1, 10'd0,    25'h0000000, 32'h3F7FFFFF, 1'b0, 1'b0);
    vecs[6]  = mk(2'd1, 3'd3, 3'd0, 2'd1, 1'b0, 8'hFF, 24'h400000, 1'b1, 8'hAA, 24'h800003, 1'b0, 10'd300,  25'h0000000, 32'h80400003, 1'b0, 1'b0);
    vecs[7]  = mk(2'd2, 3'd2, 3'd2, 2'd2, 1'b0, 8'h00, 24'h000000, 1'b0, 8'h00, 24'h000000, 1'b0, 10'd254,  25'h0000000, 32'h7F000000, 1'b0, 1'b0);
    vecs[8]  = mk(2'd2, 3'd2, 3'd2, 2'd2, 1'b0, 8'h00, 24'h000000, 1'b0, 8'h00, 24'h000000, 1'b0, 10'd1,    25'h0000005, 32'h00800005, 1'b0, 1'b0);
    vecs[9]  = mk(2'd2, 3'd2, 3'd2, 2'd2, 1'b0, 8'h00, 24'h000000, 1'b0, 8'h00, 24'h000000, 1'b1, 10'd0,    25'h0FFFFFF, 32'h80000000, 1'b0, 1'b1);
    vecs[10] = mk(2'd2, 3'd2, 3'd2, 2'd2, 1'b0, 8'h00, 24'h000000, 1'b0, 8'h00, 24'h000000, 1'b1, 10'h1FF,  25'h0FFFFFF, 32'hFF800000, 1'b1, 1'b0);
    vecs[11] = mk(2'd0, 3'd5, 3'd6, 2'd3, 1'b1, 8'h55, 24'hFFFFFF, 1'b0, 8'h00, 24'h000000, 1'b0, 10'd255,  25'h0000000, 32'h80000000, 1'b0, 1'b0);
    vecs[12] = mk(2'd2, 3'd0, 3'd2, 2'd2, 1'b0, 8'h10, 24'h000000, 1'b0, 8'h00, 24'h000000, 1'b0, 10'd255,  25'h0001234, 32'h08001234, 1'b0, 1'b0);

    in_valid = 1'b0;
    out_ready = 1'b1;
    flag_clear = 1'b0;
    driveInputs(vecs[0]);
    s_in_valid = 1'b0;
    s_out_ready = 1'b1;
    s_operand_sign_a = 1'b1;
    s_operand_exponent_a = 5'h0F;
    s_operand_fraction_a = 11'h600;

    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_in_ready", in_ready, 1'b1);
    checkOutput("reset_flags", {flag_overflow, flag_underflow}, 2'b00);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(vecs[0]);
    checkOutput("latency_not_early", out_valid, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("latency_two_cycles", out_valid, 1'b1);
    checkOutput("latency_result", result, 32'hBFC00000);
    drainPipe();

    foreach (vecs[i]) applyStimulus(vecs[i]);
    drainPipe();
    pulseClear();
    checkOutput("clear_after_table", {flag_overflow, flag_underflow}, 2'b00);

    applyStimulus(vecs[1]);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("overflow_set", flag_overflow, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("overflow_sticky", flag_overflow, 1'b1);
    pulseClear();
    checkOutput("overflow_cleared", flag_overflow, 1'b0);

    applyStimulus(vecs[2]);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOutput("underflow_set", flag_underflow, 1'b1);
    applyStimulus(vecs[9]);
    @(posedge clk);
    #1;
    checkOutput("underflow_word_waiting", out_valid, 1'b1);
    pulseClear();
    checkOutput("set_beats_clear", flag_underflow, 1'b1);
    pulseClear();
    checkOutput("underflow_cleared", flag_underflow, 1'b0);
    drainPipe();

    out_ready = 1'b0;
    applyStimulus(vecs[3]);
    applyStimulus(vecs[4]);
    driveInputs(vecs[5]);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", in_ready, 1'b0);
      checkOutput("stall_out_valid", out_valid, 1'b1);
      checkOutput("stall_result", result, 32'h7FC00000);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    applyStimulus(vecs[5]);
    drainPipe();

    applyStimulus(vecs[0]);
    applyStimulus(vecs[4]);
    reset_n = 1'b0;
    sb_q.delete();
    #1;
    checkOutput("midreset_out_valid", out_valid, 1'b0);
    checkOutput("midreset_result", result, 32'd0);
    checkOutput("midreset_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("no_stale_output", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    applyStimulus(vecs[6]);
    checkOutput("post_reset_not_early", out_valid, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("post_reset_latency", out_valid, 1'b1);
    drainPipe();

    s_in_valid = 1'b1;
    @(negedge clk);
    checkOutput("half_in_ready", s_in_ready, 1'b1);
    @(posedge clk);
    #1 s_in_valid = 1'b0;
    checkOutput("half_not_early", s_out_valid, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("half_out_valid", s_out_valid, 1'b1);
    checkOutput("half_result", s_result, 16'hBE00);
    @(posedge clk);
    #1;

    s_out_ready = 1'b0;
    s_in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 s_in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("half_reset_out_valid", s_out_valid, 1'b0);
    checkOutput("half_reset_result", s_result, 16'h0000);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    s_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("half_no_stale_output", s_out_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
